// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Bit-index counter width; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Combinational 1-bit full adder used as the serial adder's arithmetic stage.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder stage, LSB-first, WIDTH cycles per add.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-2:0] sum_sr_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_next;

    fa_bit u_fa (
        .a  (a_sr_q[0]),
        .b  (b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; on the final bit this is the full result.
    assign sum_next = {fa_s, sum_sr_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    sum_sr_q <= sum_next[WIDTH-1:1];
                    carry_q  <= fa_co;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        sum     <= sum_next;
                        cout    <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_q is the carry into the MSB on this final step
                        ovf     <= carry_q ^ fa_co;
`endif
                        cnt_q   <= '0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
